id_hazard_scheduler: RTL and testbench

//  Issue scheduler for the decode stage. Keeps a per-register scoreboard of in-flight writes and raises

---
 rtl/id_hazard_scheduler_if.sv | 34 +++
 rtl/id_hazard_scheduler.sv | 107 ++++++++++
 tb/tb_id_hazard_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_scheduler_if.sv
// rtl/id_hazard_scheduler_if.sv - decode-stage issue scheduler signal bundle
interface id_hazard_scheduler_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  forward_en;
  logic                  freeze;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  logic                  br_taken;
  logic                  drain_req;
  logic                  hazard_detected;
  logic                  pc_freeze;
  logic                  ifid_flush;
  logic                  drained;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output forward_en, freeze, id_valid, id_src1, id_src2, id_src2_used,
           id_dest, id_wb_en, id_mem_r_en, br_taken, drain_req,
    input  hazard_detected, pc_freeze, ifid_flush, drained, stall_cycles
  );

  modport slave (
    input  forward_en, freeze, id_valid, id_src1, id_src2, id_src2_used,
           id_dest, id_wb_en, id_mem_r_en, br_taken, drain_req,
    output hazard_detected, pc_freeze, ifid_flush, drained, stall_cycles
  );
endinterface

// File: rtl/id_hazard_scheduler.sv
// rtl/id_hazard_scheduler.sv - decode-stage scoreboard, hazard stall, branch flush and drain control
module id_hazard_scheduler #(
  parameter int REG_ADDR_W = 5,
  parameter int WB_LATENCY = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  id_hazard_scheduler_if.slave  bus
);
  localparam int              NREG = 2 ** REG_ADDR_W;
  localparam int              CW   = $clog2(WB_LATENCY + 1);
  localparam logic [CW-1:0]   LAT  = CW'(WB_LATENCY);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt [NREG];
  logic [NREG-1:0]   ld;
  logic              hit1;
  logic              hit2;
  logic              hazard;
  logic              issue;
  logic              sb_empty;
  logic              drained_q;
  logic [CNT_W-1:0]  stall_q;

  // Source hits: a pending write blocks the reader unless forwarding can cover it;
  // a load still in EXE (count just loaded) can never be forwarded in time.
  always_comb begin
    hit1   = (bus.id_src1 != '0) && (cnt[bus.id_src1] != '0) &&
             (!bus.forward_en || (ld[bus.id_src1] && (cnt[bus.id_src1] == LAT)));
    hit2   = (bus.id_src2 != '0) && (cnt[bus.id_src2] != '0) &&
             (!bus.forward_en || (ld[bus.id_src2] && (cnt[bus.id_src2] == LAT)));
    hazard = bus.id_valid && (hit1 || (bus.id_src2_used && hit2));
  end

  // Scoreboard is empty when no register has a write in flight.
  always_comb begin
    sb_empty = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      if (cnt[r] != '0) sb_empty = 1'b0;
    end
  end

  assign issue = bus.id_valid && !hazard && !bus.freeze && (state == RUN);

  assign bus.hazard_detected = hazard;
  assign bus.pc_freeze       = hazard || bus.freeze || (state != RUN);
  assign bus.ifid_flush      = bus.br_taken && !hazard && !bus.freeze;
  assign bus.drained         = drained_q;
  assign bus.stall_cycles    = stall_q;

  // Per-register write countdown; a fresh issue to a register restarts its count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      ld <= '0;
    end else if (!bus.freeze) begin
      for (int r = 1; r < NREG; r++) begin
        if (issue && bus.id_wb_en && (bus.id_dest == REG_ADDR_W'(r))) begin
          cnt[r] <= LAT;
          ld[r]  <= bus.id_mem_r_en;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  // Drain controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Drain controller next state; withdrawing the request aborts a drain in progress.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.drain_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!bus.drain_req) state_nxt = RUN;
        else if (sb_empty)  state_nxt = DRAINED;
      end
      DRAINED: if (!bus.drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Registered drain-complete flag tracks entry to and exit from DRAINED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drained_q <= 1'b0;
    else      drained_q <= (state_nxt == DRAINED);
  end

  // Saturating count of cycles lost to data hazards while the pipeline advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          stall_q <= '0;
    else if (hazard && !bus.freeze && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_id_hazard_scheduler.sv
// tb/tb_id_hazard_scheduler.sv - bench for id_hazard_scheduler against an in-flight write list model
module tb_id_hazard_scheduler;
  localparam int RW   = 5;
  localparam int L    = 3;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_hazard_scheduler_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();
  id_hazard_scheduler #(.REG_ADDR_W(RW), .WB_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int dest;
    bit load;
    int age;
  } wr_t;

  wr_t inflight[$];
  int  m_state;
  int  m_stall;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The youngest in-flight write to a register decides whether a reader must wait.
  function automatic bit m_hit(input int s);
    if (s == 0) return 1'b0;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if (inflight[i].dest == s)
        return !bus.forward_en || (inflight[i].load && inflight[i].age == 0);
    end
    return 1'b0;
  endfunction

  function automatic bit m_haz();
    return bus.id_valid && (m_hit(int'(bus.id_src1)) ||
                            (bus.id_src2_used && m_hit(int'(bus.id_src2))));
  endfunction

  task automatic set_in(input bit v, input int s1, input int s2, input bit s2u,
                        input int d, input bit wb, input bit ldi, input bit br);
    bus.id_valid     = v;
    bus.id_src1      = RW'(s1);
    bus.id_src2      = RW'(s2);
    bus.id_src2_used = s2u;
    bus.id_dest      = RW'(d);
    bus.id_wb_en     = wb;
    bus.id_mem_r_en  = ldi;
    bus.br_taken     = br;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    inflight.delete();
    m_state = M_RUN;
    m_stall = 0;
    chk("rst_drained", bus.drained, 0);
    chk("rst_stall", bus.stall_cycles, 0);
    chk("rst_hazard", bus.hazard_detected, 0);
    chk("rst_pc_freeze", bus.pc_freeze, bus.freeze);
    chk("rst_flush", bus.ifid_flush, bus.br_taken && !bus.freeze);
    #2;
    rst = 1'b1;
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(output logic o_haz, output logic o_flush, output logic o_drained, output logic o_pcf);
    bit h, iss, empty;
    int nst;
    @(negedge clk);
    h     = m_haz();
    iss   = bus.id_valid && !h && !bus.freeze && (m_state == M_RUN);
    empty = (inflight.size() == 0);
    chk("hazard", bus.hazard_detected, h);
    chk("pc_freeze", bus.pc_freeze, h || bus.freeze || (m_state != M_RUN));
    chk("ifid_flush", bus.ifid_flush, bus.br_taken && !h && !bus.freeze);
    chk("drained", bus.drained, m_state == M_DRAINED);
    chk("stall_cycles", bus.stall_cycles, m_stall);
    o_haz = bus.hazard_detected; o_flush = bus.ifid_flush;
    o_drained = bus.drained; o_pcf = bus.pc_freeze;
    nst = m_state;
    if (m_state == M_RUN && bus.drain_req) nst = M_DRAIN;
    else if (m_state == M_DRAIN) nst = !bus.drain_req ? M_RUN : (empty ? M_DRAINED : M_DRAIN);
    else if (m_state == M_DRAINED && !bus.drain_req) nst = M_RUN;
    @(posedge clk);
    if (!bus.freeze) begin
      foreach (inflight[i]) inflight[i].age++;
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].age >= L) inflight.delete(i);
      if (iss && bus.id_wb_en && bus.id_dest != 0)
        inflight.push_back('{dest: int'(bus.id_dest), load: bus.id_mem_r_en, age: 0});
      if (h && m_stall < SMAX) m_stall++;
    end
    m_state = nst;
    #1;
  endtask

  task automatic wait_issue(output int n);
    logic h, f, d, p;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(h, f, d, p);
      if (!h) break;
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic h, f, d, p;
    int   n;
    bus.forward_en = 1'b1;
    bus.freeze     = 1'b0;
    bus.drain_req  = 1'b0;
    idle();
    do_reset();
    bus.freeze = 1'b1;
    #0;
    chk("rst_pc_freeze_follows", bus.pc_freeze, 1);
    bus.freeze = 1'b0;

    // ADD r3 then dependent SUB with forwarding: no stall
    set_in(1, 1, 2, 1, 3, 1, 0, 0); step(h, f, d, p);
    set_in(1, 3, 5, 1, 4, 1, 0, 0); step(h, f, d, p);
    chk("t1_sub_hazard", h, 0);
    idle(); repeat (3) step(h, f, d, p);
    chk("t1_stall", bus.stall_cycles, 0);

    // load-use with forwarding: one bubble
    do_reset();
    set_in(1, 1, 0, 0, 3, 1, 1, 0); step(h, f, d, p);
    set_in(1, 3, 1, 1, 4, 1, 0, 0); wait_issue(n);
    chk("t2_bubbles", n, 1);
    idle(); step(h, f, d, p);
    chk("t2_stall", bus.stall_cycles, 1);

    // no forwarding: stall until write-back; r0 never stalls
    do_reset();
    bus.forward_en = 1'b0;
    set_in(1, 1, 2, 1, 3, 1, 0, 0); step(h, f, d, p);
    set_in(1, 3, 0, 0, 4, 1, 0, 0); wait_issue(n);
    chk("t3_bubbles", n, 3);
    idle(); step(h, f, d, p);
    chk("t3_stall", bus.stall_cycles, 3);
    set_in(1, 1, 2, 1, 0, 1, 0, 0); step(h, f, d, p);
    set_in(1, 0, 0, 1, 4, 1, 0, 0); wait_issue(n);
    chk("t3_r0_bubbles", n, 0);

    // branch flush, alone and behind a load-use stall
    do_reset();
    bus.forward_en = 1'b1;
    set_in(1, 1, 2, 1, 0, 0, 0, 1); step(h, f, d, p);
    chk("t4_flush", f, 1);
    idle(); step(h, f, d, p);
    chk("t4_flush_pulse", f, 0);
    set_in(1, 1, 0, 0, 3, 1, 1, 0); step(h, f, d, p);
    set_in(1, 3, 1, 1, 0, 0, 0, 1); step(h, f, d, p);
    chk("t4_haz_flush_blocked", f, 0);
    step(h, f, d, p);
    chk("t4_haz_flush_issue", f, 1);
    idle(); step(h, f, d, p);

    // freeze holds the scoreboard
    do_reset();
    bus.forward_en = 1'b0;
    set_in(1, 1, 0, 0, 3, 1, 1, 0); step(h, f, d, p);
    idle(); bus.freeze = 1'b1;
    repeat (4) step(h, f, d, p);
    bus.freeze = 1'b0;
    set_in(1, 3, 0, 0, 4, 1, 0, 0); wait_issue(n);
    chk("t5_bubbles", n, 3);

    // drain after two writes
    do_reset();
    bus.forward_en = 1'b1;
    set_in(1, 1, 2, 1, 3, 1, 0, 0); step(h, f, d, p);
    set_in(1, 1, 2, 1, 4, 1, 0, 0); step(h, f, d, p);
    idle(); bus.drain_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(h, f, d, p);
      chk($sformatf("t6_not_drained_%0d", k), d, 0);
      if (k >= 2) chk($sformatf("t6_pc_freeze_%0d", k), p, 1);
    end
    step(h, f, d, p);
    chk("t6_drained", d, 1);
    chk("t6_drained_pcf", p, 1);
    bus.drain_req = 1'b0;
    step(h, f, d, p);
    chk("t6_drop_still", d, 1);
    step(h, f, d, p);
    chk("t6_run_drained", d, 0);
    chk("t6_run_pcf", p, 0);
    bus.forward_en = 1'b0;
    set_in(1, 1, 2, 1, 5, 1, 0, 0); step(h, f, d, p);
    idle(); bus.drain_req = 1'b1;
    step(h, f, d, p);
    step(h, f, d, p);
    chk("t6_mid_drain_pcf", p, 1);
    bus.drain_req = 1'b0;
    do_reset();
    set_in(1, 5, 0, 0, 6, 1, 0, 0); step(h, f, d, p);
    chk("t6_post_rst_hazard", h, 0);
    chk("t6_post_rst_pcf", p, 0);

    // randomized traffic against the model
    idle();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(199) == 0) do_reset();
      if ($urandom_range(15) == 0) bus.forward_en = ~bus.forward_en;
      if ($urandom_range(24) == 0) bus.drain_req = ~bus.drain_req;
      bus.freeze = ($urandom_range(7) == 0);
      set_in($urandom_range(3) != 0, $urandom_range(5), $urandom_range(5),
             $urandom_range(1), $urandom_range(5), $urandom_range(3) != 0,
             $urandom_range(2) == 0, $urandom_range(5) == 0);
      step(h, f, d, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
